// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the FIR MAC sequencer: state encoding,
// tap-select codes and a saturating counter helper.
package fir_seq_pkg;

    localparam int TAPS_PER_GROUP = 3;

    localparam logic [3:0] EN_MUL_NONE = 4'b0000;
    localparam logic [3:0] EN_MUL_TAP1 = 4'b0001;
    localparam logic [3:0] EN_MUL_TAP2 = 4'b0010;
    localparam logic [3:0] EN_MUL_TAP3 = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL1 = 3'd1,
        ST_MUL2 = 3'd2,
        ST_MUL3 = 3'd3,
        ST_DONE = 3'd4
    } seq_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Tapped delay line: tap 0 is the newest sample, shifted only when enabled;
// synchronous clear and reset both zero every tap.
module fir_delay_line #(
    parameter int DEPTH = 12,
    parameter int W     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               shift_en,
    input  logic [W-1:0]       din,
    output logic [DEPTH*W-1:0] taps
);

    logic [DEPTH*W-1:0] taps_q;
    logic [DEPTH*W-1:0] taps_d;

    // Next-tap selection: clear beats shift; the oldest tap falls off the top.
    always_comb begin
        taps_d = taps_q;
        if (clr) begin
            taps_d = {(DEPTH*W){1'b0}};
        end else if (shift_en) begin
            taps_d = {taps_q[(DEPTH-1)*W-1:0], din};
        end else begin
            taps_d = taps_q;
        end
    end

    // Tap storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            taps_q <= {(DEPTH*W){1'b0}};
        end else begin
            taps_q <= taps_d;
        end
    end

    assign taps = taps_q;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sample capture and 3-cycle MAC control for the transposed FIR.
// Optional busy-drop counter output enabled by FIR_SEQ_DROP_CNT_EN.
module fir_mac_sequencer
    import fir_seq_pkg::*;
#(
    parameter int NUM_GROUPS = 4,
    parameter int SAMPLE_W   = 3
) (
    input  logic                                      iClk_12M,
    input  logic                                      iRst,
    input  logic                                      iEnSample,
    input  logic signed [SAMPLE_W-1:0]                iFirIn,
    input  logic                                      iFlush,
    output logic [NUM_GROUPS*TAPS_PER_GROUP*SAMPLE_W-1:0] oDelay,
    output logic [3:0]                                oEnMul,
    output logic                                      oEnAdd,
    output logic                                      oEnAcc,
    output logic [1:0]                                oCoeffSel,
    output logic                                      oAccValid,
    output logic                                      oBusy,
    output logic                                      oDropFlag
`ifdef FIR_SEQ_DROP_CNT_EN
    ,
    output logic [7:0]                                oDropCnt
`endif
);

    localparam int DEPTH = NUM_GROUPS * TAPS_PER_GROUP;

    seq_state_t  state_q, state_d;
    logic [3:0]  en_mul_q, en_mul_d;
    logic        en_add_q, en_add_d;
    logic        en_acc_q, en_acc_d;
    logic [1:0]  coeff_sel_q, coeff_sel_d;
    logic        acc_valid_q, acc_valid_d;
    logic        busy_q, busy_d;
    logic        drop_flag_q, drop_flag_d;
    logic        ready_s;
    logic        accept_s;
    logic        drop_s;
`ifdef FIR_SEQ_DROP_CNT_EN
    logic [7:0]  drop_cnt_q, drop_cnt_d;
`endif

    // Next state plus control outputs decoded from the next state so they are registered.
    always_comb begin
        ready_s     = (state_q == ST_IDLE) || (state_q == ST_DONE);
        accept_s    = iEnSample && !iFlush && ready_s;
        drop_s      = iEnSample && !iFlush && !ready_s;
        state_d     = state_q;
        en_mul_d    = EN_MUL_NONE;
        en_add_d    = 1'b0;
        en_acc_d    = 1'b0;
        coeff_sel_d = 2'd0;
        acc_valid_d = 1'b0;
        busy_d      = 1'b0;
        if (iFlush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = accept_s ? ST_MUL1 : ST_IDLE;
                ST_MUL1: state_d = ST_MUL2;
                ST_MUL2: state_d = ST_MUL3;
                ST_MUL3: state_d = ST_DONE;
                ST_DONE: state_d = accept_s ? ST_MUL1 : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
        case (state_d)
            ST_MUL1: begin
                en_mul_d = EN_MUL_TAP1; en_add_d = 1'b1; en_acc_d = 1'b1;
                coeff_sel_d = 2'd0; busy_d = 1'b1;
            end
            ST_MUL2: begin
                en_mul_d = EN_MUL_TAP2; en_add_d = 1'b1; en_acc_d = 1'b1;
                coeff_sel_d = 2'd1; busy_d = 1'b1;
            end
            ST_MUL3: begin
                en_mul_d = EN_MUL_TAP3; en_add_d = 1'b1; en_acc_d = 1'b1;
                coeff_sel_d = 2'd2; busy_d = 1'b1;
            end
            ST_DONE: acc_valid_d = 1'b1;
            default: acc_valid_d = 1'b0;
        endcase
        if (iFlush) begin
            drop_flag_d = 1'b0;
        end else if (drop_s) begin
            drop_flag_d = 1'b1;
        end else begin
            drop_flag_d = drop_flag_q;
        end
`ifdef FIR_SEQ_DROP_CNT_EN
        if (iFlush) begin
            drop_cnt_d = 8'd0;
        end else if (drop_s) begin
            drop_cnt_d = sat_inc8(drop_cnt_q);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
`endif
    end

    // Sequencer FSM and registered control outputs.
    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            state_q     <= ST_IDLE;
            en_mul_q    <= EN_MUL_NONE;
            en_add_q    <= 1'b0;
            en_acc_q    <= 1'b0;
            coeff_sel_q <= 2'd0;
            acc_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            drop_flag_q <= 1'b0;
`ifdef FIR_SEQ_DROP_CNT_EN
            drop_cnt_q  <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            en_mul_q    <= en_mul_d;
            en_add_q    <= en_add_d;
            en_acc_q    <= en_acc_d;
            coeff_sel_q <= coeff_sel_d;
            acc_valid_q <= acc_valid_d;
            busy_q      <= busy_d;
            drop_flag_q <= drop_flag_d;
`ifdef FIR_SEQ_DROP_CNT_EN
            drop_cnt_q  <= drop_cnt_d;
`endif
        end
    end

    fir_delay_line #(
        .DEPTH (DEPTH),
        .W     (SAMPLE_W)
    ) u_delay (
        .clk      (iClk_12M),
        .rst      (iRst),
        .clr      (iFlush),
        .shift_en (accept_s),
        .din      (iFirIn),
        .taps     (oDelay)
    );

    assign oEnMul    = en_mul_q;
    assign oEnAdd    = en_add_q;
    assign oEnAcc    = en_acc_q;
    assign oCoeffSel = coeff_sel_q;
    assign oAccValid = acc_valid_q;
    assign oBusy     = busy_q;
    assign oDropFlag = drop_flag_q;
`ifdef FIR_SEQ_DROP_CNT_EN
    assign oDropCnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed self-checking bench for fir_mac_sequencer (NUM_GROUPS=4, SAMPLE_W=3).
module tb_fir_mac_sequencer;

    logic              clk;
    logic              iRst;
    logic              iEnSample;
    logic signed [2:0] iFirIn;
    logic              iFlush;
    logic [35:0]       oDelay;
    logic [3:0]        oEnMul;
    logic              oEnAdd;
    logic              oEnAcc;
    logic [1:0]        oCoeffSel;
    logic              oAccValid;
    logic              oBusy;
    logic              oDropFlag;
`ifdef FIR_SEQ_DROP_CNT_EN
    logic [7:0]        oDropCnt;
`endif

    int total = 0;
    int bad   = 0;

    // {oEnMul, oEnAdd, oEnAcc, oCoeffSel, oAccValid, oBusy}
    localparam logic [9:0] C_IDLE = 10'b0000_0_0_00_0_0;
    localparam logic [9:0] C_MUL1 = 10'b0001_1_1_00_0_1;
    localparam logic [9:0] C_MUL2 = 10'b0010_1_1_01_0_1;
    localparam logic [9:0] C_MUL3 = 10'b0011_1_1_10_0_1;
    localparam logic [9:0] C_DONE = 10'b0000_0_0_00_1_0;

    logic [9:0] ctrl;
    assign ctrl = {oEnMul, oEnAdd, oEnAcc, oCoeffSel, oAccValid, oBusy};

    fir_mac_sequencer #(.NUM_GROUPS(4), .SAMPLE_W(3)) dut (
        .iClk_12M  (clk),
        .iRst      (iRst),
        .iEnSample (iEnSample),
        .iFirIn    (iFirIn),
        .iFlush    (iFlush),
        .oDelay    (oDelay),
        .oEnMul    (oEnMul),
        .oEnAdd    (oEnAdd),
        .oEnAcc    (oEnAcc),
        .oCoeffSel (oCoeffSel),
        .oAccValid (oAccValid),
        .oBusy     (oBusy),
        .oDropFlag (oDropFlag)
`ifdef FIR_SEQ_DROP_CNT_EN
        ,
        .oDropCnt  (oDropCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [35:0] fill_exp;
        iRst = 1'b1; iEnSample = 1'b0; iFirIn = 3'sb000; iFlush = 1'b0;
        step();
        step();
        chk("rst_ctrl", 64'(ctrl), 64'(C_IDLE));
        chk("rst_delay", 64'(oDelay), 64'd0);
        chk("rst_drop", 64'(oDropFlag), 64'd0);
        iRst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_ctrl", 64'(ctrl), 64'(C_IDLE));
            chk("idle_delay", 64'(oDelay), 64'd0);
        end

        // Single sample 3: MUL1..MUL3, DONE, back to IDLE.
        iEnSample = 1'b1; iFirIn = 3'sb011;
        step();
        iEnSample = 1'b0; iFirIn = 3'sb000;
        chk("single_mul1", 64'(ctrl), 64'(C_MUL1));
        chk("single_tap0", 64'(oDelay), 64'd3);
        step();
        chk("single_mul2", 64'(ctrl), 64'(C_MUL2));
        step();
        chk("single_mul3", 64'(ctrl), 64'(C_MUL3));
        chk("single_frozen", 64'(oDelay), 64'd3);
        step();
        chk("single_done", 64'(ctrl), 64'(C_DONE));
        step();
        chk("single_idle", 64'(ctrl), 64'(C_IDLE));

        // Back-to-back: 1, then -2 strobed in DONE.
        iEnSample = 1'b1; iFirIn = 3'sb001;
        step();
        iEnSample = 1'b0;
        chk("b2b_mul1", 64'(ctrl), 64'(C_MUL1));
        step();
        step();
        step();
        chk("b2b_done1", 64'(ctrl), 64'(C_DONE));
        iEnSample = 1'b1; iFirIn = 3'sb110;
        step();
        iEnSample = 1'b0;
        chk("b2b_restart", 64'(ctrl), 64'(C_MUL1));
        chk("b2b_taps", 64'(oDelay[8:0]), 64'({3'd3, 3'd1, 3'b110}));
        step();
        step();
        step();
        chk("b2b_done2", 64'(ctrl), 64'(C_DONE));
        step();
        chk("b2b_idle", 64'(ctrl), 64'(C_IDLE));

        // Busy drop: -1 accepted, 2 strobed during MUL2 must be dropped.
        iEnSample = 1'b1; iFirIn = 3'sb111;
        step();
        iEnSample = 1'b0;
        chk("drop_noflag", 64'(oDropFlag), 64'd0);
        step();
        iEnSample = 1'b1; iFirIn = 3'sb010;
        step();
        iEnSample = 1'b0;
        chk("drop_mul3", 64'(ctrl), 64'(C_MUL3));
        chk("drop_taps", 64'(oDelay[11:0]), 64'({3'd3, 3'd1, 3'b110, 3'b111}));
        chk("drop_flag", 64'(oDropFlag), 64'd1);
        step();
        chk("drop_done", 64'(ctrl), 64'(C_DONE));
        step();
        chk("drop_idle", 64'(ctrl), 64'(C_IDLE));
        chk("drop_sticky", 64'(oDropFlag), 64'd1);
`ifdef FIR_SEQ_DROP_CNT_EN
        chk("drop_cnt", 64'(oDropCnt), 64'd1);
`endif

        // Flush at MUL2 aborts the sequence and clears taps and flag.
        iEnSample = 1'b1; iFirIn = 3'sb101;
        step();
        iEnSample = 1'b0;
        step();
        chk("flush_pre_mul2", 64'(ctrl), 64'(C_MUL2));
        iFlush = 1'b1;
        step();
        iFlush = 1'b0;
        chk("flush_ctrl", 64'(ctrl), 64'(C_IDLE));
        chk("flush_delay", 64'(oDelay), 64'd0);
        chk("flush_flag", 64'(oDropFlag), 64'd0);
`ifdef FIR_SEQ_DROP_CNT_EN
        chk("flush_cnt", 64'(oDropCnt), 64'd0);
`endif
        step();
        chk("flush_no_valid", 64'(ctrl), 64'(C_IDLE));

        // Flush together with a strobe in IDLE: sample lost, nothing flagged.
        iFlush = 1'b1; iEnSample = 1'b1; iFirIn = 3'sb011;
        step();
        iFlush = 1'b0; iEnSample = 1'b0;
        chk("coll_idle_delay", 64'(oDelay), 64'd0);
        chk("coll_idle_ctrl", 64'(ctrl), 64'(C_IDLE));
        chk("coll_idle_flag", 64'(oDropFlag), 64'd0);

        // Flush together with a strobe while busy: no drop flag either.
        iEnSample = 1'b1; iFirIn = 3'sb010;
        step();
        iFlush = 1'b1;
        step();
        iFlush = 1'b0; iEnSample = 1'b0;
        chk("coll_busy_delay", 64'(oDelay), 64'd0);
        chk("coll_busy_ctrl", 64'(ctrl), 64'(C_IDLE));
        chk("coll_busy_flag", 64'(oDropFlag), 64'd0);
`ifdef FIR_SEQ_DROP_CNT_EN
        chk("coll_busy_cnt", 64'(oDropCnt), 64'd0);
`endif

        // Fill: 13 samples 1..13 (3-bit wrap), one every 4 cycles via DONE.
        for (int v = 1; v <= 13; v++) begin
            iEnSample = 1'b1; iFirIn = 3'(v);
            step();
            iEnSample = 1'b0;
            step();
            step();
            step();
            chk("fill_done", 64'(ctrl), 64'(C_DONE));
        end
        step();
        fill_exp = 36'd0;
        for (int i = 0; i < 12; i++) begin
            fill_exp[i*3 +: 3] = 3'(13 - i);
        end
        chk("fill_idle", 64'(ctrl), 64'(C_IDLE));
        chk("fill_taps", 64'(oDelay), 64'(fill_exp));
        chk("fill_noflag", 64'(oDropFlag), 64'd0);

        // Reset wins over flush and clears a set drop flag mid-sequence.
        iEnSample = 1'b1; iFirIn = 3'sb001;
        step();
        step();
        iEnSample = 1'b0;
        chk("rst2_flag_set", 64'(oDropFlag), 64'd1);
        iRst = 1'b1; iFlush = 1'b1;
        step();
        iRst = 1'b0; iFlush = 1'b0;
        chk("rst2_ctrl", 64'(ctrl), 64'(C_IDLE));
        chk("rst2_delay", 64'(oDelay), 64'd0);
        chk("rst2_flag", 64'(oDropFlag), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
